shared_array_writer: RTL and testbench

//   Writable counterpart of the shared lookup array used by the cores. Holds a
//   2**ADDR_W x DATA_W array with two combinational read ports and two write

---
 rtl/shared_array_writer.sv | 186 ++++++++++++++++++
 tb/tb_shared_array_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shared_array_writer.sv
// -----------------------------------------------------------------------------
// shared_array_writer
//   Writable counterpart of the shared lookup array used by the cores.
//   Holds a 2**ADDR_W x DATA_W array with two combinational read ports and two
//   write ports. Writes are arbitrated round-robin, with one commit per clock.
//   After reset the block sweeps the array to Data[i] = i, one entry per clock.
//   It accepts write traffic only after this sweep has finished.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   WrValid0/1   write request from core 0/1
//   WrReady0/1   write accepted this cycle (combinational from WrValid + state)
//   WrAddr0/1    write address from core 0/1
//   WrData0/1    write data from core 0/1
//   AddressBus0/1  read port address
//   DataBus0/1     read port data (combinational, 0 while InitDone=0)
//   InitDone     array initialised, writes enabled
//
// Configuration
//   SHARED_ARRAY_BYPASS_EN : when defined, a read of the address being
//   accepted this cycle returns the incoming write data (write-through).
//   When undefined, the read returns the old value during the accept cycle.
// -----------------------------------------------------------------------------
module shared_array_writer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WrValid0,
    output logic              WrReady0,
    input  logic [ADDR_W-1:0] WrAddr0,
    input  logic [DATA_W-1:0] WrData0,
    input  logic              WrValid1,
    output logic              WrReady1,
    input  logic [ADDR_W-1:0] WrAddr1,
    input  logic [DATA_W-1:0] WrData1,
    input  logic [ADDR_W-1:0] AddressBus0,
    output logic [DATA_W-1:0] DataBus0,
    input  logic [ADDR_W-1:0] AddressBus1,
    output logic [DATA_W-1:0] DataBus1,
    output logic              InitDone
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   init_ptr_r;
    logic                last_grant_r;
    logic                init_done_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                grant0_s;
    logic                grant1_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                hit0_s;
    logic                hit1_s;

    // Round-robin arbitration: on a contest the port that did not win last goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (WrValid0 && WrValid1) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = WrValid0;
            grant1_s = WrValid1;
        end
    end

    // Ready is gated by InitDone so no write can slip in during the sweep.
    assign WrReady0 = init_done_r & grant0_s;
    assign WrReady1 = init_done_r & grant1_s;
    assign InitDone = init_done_r;

    // Control state: sweep pointer, INIT/RUN phase and last grant holder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_INIT;
            init_ptr_r   <= {ADDR_W{1'b0}};
            last_grant_r <= 1'b1;
            init_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_ptr_r <= init_ptr_r + PTR_ONE;
                    if (init_ptr_r == PTR_LAST) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (WrReady0) begin
                        last_grant_r <= 1'b0;
                    end else if (WrReady1) begin
                        last_grant_r <= 1'b1;
                    end else begin
                        last_grant_r <= last_grant_r;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_ptr_r  <= {ADDR_W{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Single write port into the array: the sweep in INIT, or the granted core in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_W{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (state_r == ST_INIT) begin
            wr_en_s   = 1'b1;
            wr_addr_s = init_ptr_r;
            wr_data_s = DATA_W'(init_ptr_r);
        end else if (WrReady0) begin
            wr_en_s   = 1'b1;
            wr_addr_s = WrAddr0;
            wr_data_s = WrData0;
        end else if (WrReady1) begin
            wr_en_s   = 1'b1;
            wr_addr_s = WrAddr1;
            wr_data_s = WrData1;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Array storage; contents are established by the sweep, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Forwarding hits: only meaningful in RUN because reads are forced to 0 otherwise.
`ifdef SHARED_ARRAY_BYPASS_EN
    assign hit0_s = wr_en_s && (AddressBus0 == wr_addr_s);
    assign hit1_s = wr_en_s && (AddressBus1 == wr_addr_s);
`else
    assign hit0_s = 1'b0;
    assign hit1_s = 1'b0;
`endif

    // Read port 0: blanked until the array is initialised.
    always_comb begin
        DataBus0 = {DATA_W{1'b0}};
        if (!init_done_r) begin
            DataBus0 = {DATA_W{1'b0}};
        end else if (hit0_s) begin
            DataBus0 = wr_data_s;
        end else begin
            DataBus0 = mem_r[AddressBus0];
        end
    end

    // Read port 1: blanked until the array is initialised.
    always_comb begin
        DataBus1 = {DATA_W{1'b0}};
        if (!init_done_r) begin
            DataBus1 = {DATA_W{1'b0}};
        end else if (hit1_s) begin
            DataBus1 = wr_data_s;
        end else begin
            DataBus1 = mem_r[AddressBus1];
        end
    end

endmodule

// File: tb/tb_shared_array_writer.sv
// -----------------------------------------------------------------------------
// tb_shared_array_writer
//   Self-checking bench for shared_array_writer (ADDR_W=8, DATA_W=8).
//   A behavioural model (array contents, sweep cycle count, last grant) is
//   checked against the DUT on every falling edge. Directed steps add literal
//   expectations at key points.
// -----------------------------------------------------------------------------
module tb_shared_array_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       WrValid0, WrValid1;
    logic       WrReady0, WrReady1;
    logic [7:0] WrAddr0, WrAddr1, WrData0, WrData1;
    logic [7:0] AddressBus0, AddressBus1, DataBus0, DataBus1;
    logic       InitDone;

    int n_cmp = 0;
    int n_err = 0;

    shared_array_writer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .WrValid0(WrValid0), .WrReady0(WrReady0), .WrAddr0(WrAddr0), .WrData0(WrData0),
        .WrValid1(WrValid1), .WrReady1(WrReady1), .WrAddr1(WrAddr1), .WrData1(WrData1),
        .AddressBus0(AddressBus0), .DataBus0(DataBus0),
        .AddressBus1(AddressBus1), .DataBus1(DataBus1),
        .InitDone(InitDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mdl_mem [256];
    int         mdl_cnt  = 0;   // rising edges seen since reset release
    bit         mdl_last = 1'b1;

    always @(negedge clk) begin
        bit         done, g0, g1;
        logic [7:0] e0, e1, wa, wd;
        if (reset === 1'b0) begin
            mdl_cnt  = 0;
            mdl_last = 1'b1;
            for (int i = 0; i < 256; i++) mdl_mem[i] = 8'(i);
            chk("rst_initdone", {31'd0, InitDone}, 32'd0);
            chk("rst_ready0",   {31'd0, WrReady0}, 32'd0);
            chk("rst_ready1",   {31'd0, WrReady1}, 32'd0);
            chk("rst_data0",    {24'd0, DataBus0}, 32'd0);
            chk("rst_data1",    {24'd0, DataBus1}, 32'd0);
        end else if (reset === 1'b1) begin
            done = (mdl_cnt >= 256);
            g0 = 1'b0;
            g1 = 1'b0;
            if (done) begin
                if (WrValid0 && WrValid1) begin
                    g0 = (mdl_last == 1'b1);
                    g1 = (mdl_last == 1'b0);
                end else begin
                    g0 = WrValid0;
                    g1 = WrValid1;
                end
            end
            wa = g0 ? WrAddr0 : WrAddr1;
            wd = g0 ? WrData0 : WrData1;
            e0 = done ? mdl_mem[AddressBus0] : 8'h00;
            e1 = done ? mdl_mem[AddressBus1] : 8'h00;
`ifdef SHARED_ARRAY_BYPASS_EN
            if ((g0 || g1) && AddressBus0 == wa) e0 = wd;
            if ((g0 || g1) && AddressBus1 == wa) e1 = wd;
`endif
            chk("initdone", {31'd0, InitDone}, {31'd0, done});
            chk("ready0",   {31'd0, WrReady0}, {31'd0, g0});
            chk("ready1",   {31'd0, WrReady1}, {31'd0, g1});
            chk("data0",    {24'd0, DataBus0}, {24'd0, e0});
            chk("data1",    {24'd0, DataBus1}, {24'd0, e1});
            // Commit what the upcoming rising edge will do.
            if (g0 || g1) begin
                mdl_mem[wa] = wd;
                mdl_last    = g1;
            end
            if (mdl_cnt < 256) mdl_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int k0, k1;
        reset = 1'b1;
        WrValid0 = 1'b0; WrValid1 = 1'b0;
        WrAddr0 = 8'h00; WrAddr1 = 8'h00; WrData0 = 8'h00; WrData1 = 8'h00;
        AddressBus0 = 8'h00; AddressBus1 = 8'h00;
        #2 reset = 1'b0;

        // 1: reset 3 clocks, sweep with a pending write that must not be taken
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        WrValid0 = 1'b1; WrAddr0 = 8'h77; WrData0 = 8'h99;
        repeat (255) @(posedge clk);
        #1 chk("t1_initdone_255", {31'd0, InitDone}, 32'd0);
        chk("t1_ready_init", {31'd0, WrReady0}, 32'd0);
        // 3: both valid from the first RUN cycle
        WrAddr0 = 8'h20; WrData0 = 8'h55;
        WrValid1 = 1'b1; WrAddr1 = 8'h21; WrData1 = 8'h66;
        AddressBus0 = 8'h00; AddressBus1 = 8'h7F;
        @(posedge clk);
        #1 chk("t1_initdone_256", {31'd0, InitDone}, 32'd1);
        chk("t1_rd00", {24'd0, DataBus0}, 32'h00);
        chk("t1_rd7f", {24'd0, DataBus1}, 32'h7F);
        chk("t3_ready0_first", {31'd0, WrReady0}, 32'd1);
        chk("t3_ready1_first", {31'd0, WrReady1}, 32'd0);
        AddressBus0 = 8'hFF;
        #1 chk("t1_rdff", {24'd0, DataBus0}, 32'hFF);
        @(posedge clk);
        #1 WrValid0 = 1'b0;
        #1 chk("t3_ready1_second", {31'd0, WrReady1}, 32'd1);
        @(posedge clk);
        #1 WrValid1 = 1'b0;
        AddressBus0 = 8'h20; AddressBus1 = 8'h21;
        #1 chk("t3_rd20", {24'd0, DataBus0}, 32'h55);
        chk("t3_rd21", {24'd0, DataBus1}, 32'h66);

        // 4: sustained contest alternates 0,1,0,1,0,1
        k0 = 0; k1 = 0;
        WrValid0 = 1'b1; WrValid1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            WrAddr0 = 8'(8'h30 + k0); WrData0 = 8'(8'h80 + k0);
            WrAddr1 = 8'(8'h50 + k1); WrData1 = 8'(8'hC0 + k1);
            #1 chk("t4_ready0", {31'd0, WrReady0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t4_ready1", {31'd0, WrReady1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1 if (i % 2 == 0) k0++; else k1++;
        end
        WrValid0 = 1'b0; WrValid1 = 1'b0;
        AddressBus0 = 8'h32; AddressBus1 = 8'h52;
        #1 chk("t4_rd32", {24'd0, DataBus0}, 32'h82);
        chk("t4_rd52", {24'd0, DataBus1}, 32'hC2);

        // 2: single write, readback on port 1 the next cycle
        WrValid0 = 1'b1; WrAddr0 = 8'h10; WrData0 = 8'hA5;
        #1 chk("t2_ready0", {31'd0, WrReady0}, 32'd1);
        @(posedge clk);
        #1 WrValid0 = 1'b0; AddressBus1 = 8'h10;
        #1 chk("t2_rd10", {24'd0, DataBus1}, 32'hA5);

        // 6: read of the address being written in the accept cycle
        WrValid0 = 1'b1; WrAddr0 = 8'h40; WrData0 = 8'h3C; AddressBus0 = 8'h40;
`ifdef SHARED_ARRAY_BYPASS_EN
        #1 chk("t6_accept_rd", {24'd0, DataBus0}, 32'h3C);
`else
        #1 chk("t6_accept_rd", {24'd0, DataBus0}, 32'h40);
`endif
        @(posedge clk);
        #1 WrValid0 = 1'b0; AddressBus1 = 8'h40;
        #1 chk("t6_next_rd0", {24'd0, DataBus0}, 32'h3C);
        chk("t6_next_rd1", {24'd0, DataBus1}, 32'h3C);

        // 5: reset mid-RUN with a write in flight, then reset again mid-sweep
        WrValid0 = 1'b1; WrAddr0 = 8'h11; WrData0 = 8'hDD;
        #1 reset = 1'b0;
        #1 chk("t5_ready_in_reset", {31'd0, WrReady0}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1; WrValid0 = 1'b0;
        repeat (100) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (255) @(posedge clk);
        #1 chk("t5_initdone_255", {31'd0, InitDone}, 32'd0);
        @(posedge clk);
        #1 chk("t5_initdone_256", {31'd0, InitDone}, 32'd1);
        AddressBus0 = 8'h10; AddressBus1 = 8'h64;
        #1 chk("t5_rd10", {24'd0, DataBus0}, 32'h10);
        chk("t5_rd64", {24'd0, DataBus1}, 32'h64);
        AddressBus0 = 8'h11;
        #1 chk("t5_rd11_dropped", {24'd0, DataBus0}, 32'h11);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
